cgra_cfg_loader: RTL and testbench

- Configuration front-end for the CGRA array; sits directly upstream of the tile scan chain.
- Accepts parallel configuration words from a host over a valid/ready handshake and serializes them LSB-first into the chain serial input.
- Drives program_mode, which qualifies every chain shift.
- Optional readback pass recirculates the chain through itself. It compares a CRC-16 of the bits shifted out against a CRC-16 of the bits loaded, so configuration is verified without being destroyed.

---
 rtl/cgra_cfg_pkg.sv | 22 ++
 rtl/cgra_cfg_crc16.sv | 35 +++
 rtl/cgra_cfg_loader.sv | 171 +++++++++++++++++
 tb/tb_cgra_cfg_loader.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cgra_cfg_pkg.sv
// Shared definitions for the CGRA configuration loader: FSM encoding,
// CRC-16-CCITT constants and the bit-serial CRC step.
package cgra_cfg_pkg;

  typedef logic [1:0] cfg_state_t;

  localparam cfg_state_t ST_IDLE   = 2'd0;
  localparam cfg_state_t ST_LOAD   = 2'd1;
  localparam cfg_state_t ST_VERIFY = 2'd2;
  localparam cfg_state_t ST_FINISH = 2'd3;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // One serial step with MSB-of-register feedback.
  function automatic logic [15:0] crc16Next(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    crc16Next = {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/cgra_cfg_crc16.sv
// Bit-serial CRC-16-CCITT accumulator; init has priority over enable.
module cgra_cfg_crc16
  import cgra_cfg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init_i,
  input  logic        en_i,
  input  logic        bit_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init_i) begin
      crc_d = CRC16_INIT;
    end else if (en_i) begin
      crc_d = crc16Next(crc_q, bit_i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc_q <= CRC16_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/cgra_cfg_loader.sv
// Host-to-scan-chain configuration loader: serializes host words LSB-first
// into the tile chain and optionally verifies it by CRC over a recirculating readback.
module cgra_cfg_loader
  import cgra_cfg_pkg::*;
#(
  parameter int WORD_W        = 32,
  parameter int NUM_TILES     = 4,
  parameter int TILE_CFG_BITS = 64,
  parameter int CHAIN_BITS    = NUM_TILES * TILE_CFG_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              verify_en,
  input  logic [WORD_W-1:0] cfg_word,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              program_mode,
  output logic              chain_tdi,
  input  logic              chain_tdo,
  output logic              busy,
  output logic              done,
  output logic              crc_err
);

  localparam int NUM_WORDS = CHAIN_BITS / WORD_W;
  localparam int WCNT_W    = $clog2(NUM_WORDS + 1);
  localparam int BIT_W     = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int VCNT_W    = $clog2(CHAIN_BITS + 2);

  localparam logic [BIT_W-1:0]  LAST_BIT    = BIT_W'(WORD_W - 1);
  localparam logic [WCNT_W-1:0] WORDS_INIT  = WCNT_W'(NUM_WORDS);
  localparam logic [VCNT_W-1:0] VCNT_SHIFTS = VCNT_W'(CHAIN_BITS);
  localparam logic [VCNT_W-1:0] VCNT_CMP    = VCNT_W'(CHAIN_BITS + 1);

  cfg_state_t        state_q, state_d;
  logic              verify_q, verify_d;
  logic              err_q, err_d;
  logic [WCNT_W-1:0] wordsLeft_q, wordsLeft_d;
  logic [WORD_W-1:0] shReg_q, shReg_d;
  logic [BIT_W-1:0]  bitIdx_q, bitIdx_d;
  logic              shValid_q, shValid_d;
  logic              tdiHold_q, tdiHold_d;
  logic [VCNT_W-1:0] vcnt_q, vcnt_d;

  logic        loadActive;
  logic        lastBit;
  logic        xfer;
  logic        loadShift;
  logic        verifyShift;
  logic        startAcc;
  logic [15:0] crcIn;
  logic [15:0] crcOut;

  assign loadActive  = (state_q == ST_LOAD);
  assign lastBit     = shValid_q && (bitIdx_q == LAST_BIT);
  // Ready on the last bit too, so back-to-back words stream without a bubble.
  assign cfg_ready   = loadActive && (wordsLeft_q != '0) && (!shValid_q || lastBit);
  assign xfer        = cfg_valid && cfg_ready;
  assign loadShift   = loadActive && shValid_q;
  // VERIFY spends its first cycle idle and its last cycle comparing.
  assign verifyShift = (state_q == ST_VERIFY) && (vcnt_q != '0) && (vcnt_q <= VCNT_SHIFTS);
  assign startAcc    = (state_q == ST_IDLE) && start;

  assign program_mode = loadShift || verifyShift;
  assign chain_tdi    = verifyShift ? chain_tdo : (loadShift ? shReg_q[0] : tdiHold_q);
  assign busy         = loadActive || (state_q == ST_VERIFY);
  assign done         = (state_q == ST_FINISH);
  assign crc_err      = err_q;

  always_comb begin
    state_d     = state_q;
    verify_d    = verify_q;
    err_d       = err_q;
    wordsLeft_d = wordsLeft_q;
    shReg_d     = shReg_q;
    bitIdx_d    = bitIdx_q;
    shValid_d   = shValid_q;
    tdiHold_d   = program_mode ? chain_tdi : tdiHold_q;
    vcnt_d      = vcnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_LOAD;
          verify_d    = verify_en;
          err_d       = 1'b0;
          wordsLeft_d = WORDS_INIT;
          shValid_d   = 1'b0;
          bitIdx_d    = '0;
        end
      end
      ST_LOAD: begin
        if (loadShift) begin
          shReg_d  = shReg_q >> 1;
          bitIdx_d = bitIdx_q + BIT_W'(1);
          if (lastBit) begin
            shValid_d = 1'b0;
            bitIdx_d  = '0;
            if (wordsLeft_q == '0) begin
              state_d = verify_q ? ST_VERIFY : ST_FINISH;
              vcnt_d  = '0;
            end
          end
        end
        if (xfer) begin
          shReg_d     = cfg_word;
          shValid_d   = 1'b1;
          bitIdx_d    = '0;
          wordsLeft_d = wordsLeft_q - WCNT_W'(1);
        end
      end
      ST_VERIFY: begin
        vcnt_d = vcnt_q + VCNT_W'(1);
        if (vcnt_q == VCNT_CMP) begin
          err_d   = (crcOut != crcIn);
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      verify_q    <= 1'b0;
      err_q       <= 1'b0;
      wordsLeft_q <= '0;
      shReg_q     <= '0;
      bitIdx_q    <= '0;
      shValid_q   <= 1'b0;
      tdiHold_q   <= 1'b0;
      vcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      verify_q    <= verify_d;
      err_q       <= err_d;
      wordsLeft_q <= wordsLeft_d;
      shReg_q     <= shReg_d;
      bitIdx_q    <= bitIdx_d;
      shValid_q   <= shValid_d;
      tdiHold_q   <= tdiHold_d;
      vcnt_q      <= vcnt_d;
    end
  end

  cgra_cfg_crc16 u_crcIn (
    .clk    (clk),
    .rst    (rst),
    .init_i (startAcc),
    .en_i   (loadShift),
    .bit_i  (chain_tdi),
    .crc_o  (crcIn)
  );

  cgra_cfg_crc16 u_crcOut (
    .clk    (clk),
    .rst    (rst),
    .init_i (startAcc),
    .en_i   (verifyShift),
    .bit_i  (chain_tdo),
    .crc_o  (crcOut)
  );

endmodule

// File: tb/tb_cgra_cfg_loader.sv
// Self-checking bench for cgra_cfg_loader with a behavioural scan-chain model
// and a scoreboard of the bits expected to land in the chain.
module tb_cgra_cfg_loader;

  localparam int WORD_W     = 32;
  localparam int CHAIN_BITS = 256;
  localparam int NUM_WORDS  = CHAIN_BITS / WORD_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              verify_en;
  logic [WORD_W-1:0] cfg_word;
  logic              cfg_valid;
  logic              cfg_ready;
  logic              program_mode;
  logic              chain_tdi;
  logic              chain_tdo;
  logic              busy;
  logic              done;
  logic              crc_err;

  always #5 clk = ~clk;

  cgra_cfg_loader #(
    .WORD_W        (WORD_W),
    .NUM_TILES     (4),
    .TILE_CFG_BITS (64)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .verify_en    (verify_en),
    .cfg_word     (cfg_word),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .program_mode (program_mode),
    .chain_tdi    (chain_tdi),
    .chain_tdo    (chain_tdo),
    .busy         (busy),
    .done         (done),
    .crc_err      (crc_err)
  );

  // Scan-chain model: shifts toward the top index only when program_mode is high.
  logic [CHAIN_BITS-1:0] chain = '0;
  int  cycle      = 0;
  int  pmCount    = 0;
  int  xferCount  = 0;
  int  doneCount  = 0;
  int  doneCycle  = 0;
  bit  corruptArm = 1'b0;
  int  corruptAt  = 0;

  assign chain_tdo = chain[CHAIN_BITS-1];

  always @(posedge clk) begin : chainModel
    logic [CHAIN_BITS-1:0] nxt;
    cycle++;
    nxt = {chain[CHAIN_BITS-2:0], chain_tdi};
    if (program_mode) begin
      pmCount++;
      if (corruptArm && (pmCount == corruptAt)) nxt[100] = ~nxt[100];
      chain <= nxt;
    end
    if (cfg_valid && cfg_ready) xferCount++;
    if (done) begin
      doneCount++;
      doneCycle = cycle;
    end
  end

  bit expQ[$];
  int nChecks = 0;
  int nFails  = 0;

  task automatic checkOutput(input string tag, input logic [CHAIN_BITS-1:0] got,
                             input logic [CHAIN_BITS-1:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Hold a word on the bus until it is accepted; its bits become expected chain content.
  task automatic sendWord(input logic [WORD_W-1:0] w);
    cfg_word  = w;
    cfg_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (cfg_ready) begin
        for (int b = 0; b < WORD_W; b++) expQ.push_back(w[b]);
        @(negedge clk);
        start = 1'b0;
        return;
      end
      @(negedge clk);
      start = 1'b0;
    end
    checkOutput("readyTimeout", cfg_ready, 1);
  endtask

  task automatic waitDone(input int maxCycles);
    for (int i = 0; i < maxCycles; i++) begin
      if (done) begin
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    checkOutput("doneTimeout", done, 1);
  endtask

  task automatic checkChain(input string tag, input int flipBit);
    logic [CHAIN_BITS-1:0] exp;
    exp = '0;
    for (int k = 0; k < CHAIN_BITS; k++) begin
      if (expQ.size() > 0) exp[CHAIN_BITS-1-k] = expQ.pop_front();
    end
    if (flipBit >= 0) exp[flipBit] = ~exp[flipBit];
    checkOutput(tag, chain, exp);
  endtask

  // Full load of words 1..NUM_WORDS; optional host stall after stallIdx and
  // a stray start pulse alongside word busyIdx.
  task automatic applyStimulus(input logic ven, input int stallIdx, input int busyIdx,
                               output int firstXfer);
    firstXfer = 0;
    start     = 1'b1;
    verify_en = ven;
    @(negedge clk);
    start = 1'b0;
    for (int w = 0; w < NUM_WORDS; w++) begin
      if (w == busyIdx) begin
        start     = 1'b1;
        verify_en = ~ven;
      end
      sendWord(WORD_W'(w + 1));
      if (w == 0) firstXfer = cycle;
      if (w == stallIdx) begin
        cfg_valid = 1'b0;
        repeat (WORD_W) @(negedge clk);
        for (int g = 0; g < 5; g++) begin
          checkOutput("stallPm", program_mode, 0);
          @(negedge clk);
        end
      end
    end
    cfg_valid = 1'b0;
    waitDone(2000);
  endtask

  initial begin : watchdog
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int firstXfer;
    int pmBase;
    int xferBase;
    int doneBase;

    rst       = 1'b0;
    start     = 1'b0;
    verify_en = 1'b0;
    cfg_valid = 1'b0;
    cfg_word  = '0;
    repeat (2) @(negedge clk);
    checkOutput("rstPm", program_mode, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstReady", cfg_ready, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstErr", crc_err, 0);
    checkOutput("rstTdi", chain_tdi, 0);
    rst = 1'b1;
    @(negedge clk);

    cfg_valid = 1'b1;
    cfg_word  = 32'hDEADBEEF;
    @(negedge clk);
    checkOutput("idleReady", cfg_ready, 0);
    checkOutput("idleBusy", busy, 0);
    cfg_valid = 1'b0;

    $display("[TB] basic load");
    pmBase   = pmCount;
    xferBase = xferCount;
    applyStimulus(1'b0, -1, -1, firstXfer);
    checkOutput("basicShifts", pmCount - pmBase, CHAIN_BITS);
    checkOutput("basicLatency", doneCycle - firstXfer, CHAIN_BITS + 1);
    checkOutput("basicWords", xferCount - xferBase, NUM_WORDS);
    checkOutput("basicErr", crc_err, 0);
    checkChain("basicChain", -1);

    $display("[TB] load with verify");
    pmBase = pmCount;
    applyStimulus(1'b1, -1, -1, firstXfer);
    checkOutput("verifyShifts", pmCount - pmBase, 2 * CHAIN_BITS);
    checkOutput("verifyErr", crc_err, 0);
    checkChain("verifyChain", -1);

    $display("[TB] corrupted readback");
    pmBase     = pmCount;
    corruptAt  = pmBase + CHAIN_BITS;
    corruptArm = 1'b1;
    applyStimulus(1'b1, -1, -1, firstXfer);
    corruptArm = 1'b0;
    checkOutput("corruptErr", crc_err, 1);
    checkChain("corruptChain", 100);
    repeat (5) @(negedge clk);
    checkOutput("errSticky", crc_err, 1);

    $display("[TB] host stall");
    pmBase = pmCount;
    applyStimulus(1'b0, 2, -1, firstXfer);
    checkOutput("stallShifts", pmCount - pmBase, CHAIN_BITS);
    checkOutput("errCleared", crc_err, 0);
    checkChain("stallChain", -1);

    $display("[TB] reset mid-load");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int w = 0; w < 5; w++) sendWord(WORD_W'(w + 1));
    repeat (10) @(negedge clk);
    checkOutput("preRstPm", program_mode, 1);
    #2 rst = 1'b0;
    #1;
    checkOutput("asyncPm", program_mode, 0);
    checkOutput("asyncBusy", busy, 0);
    checkOutput("asyncReady", cfg_ready, 0);
    expQ.delete();
    cfg_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    pmBase = pmCount;
    applyStimulus(1'b0, -1, -1, firstXfer);
    checkOutput("reloadShifts", pmCount - pmBase, CHAIN_BITS);
    checkChain("reloadChain", -1);

    $display("[TB] start while busy");
    pmBase   = pmCount;
    xferBase = xferCount;
    doneBase = doneCount;
    applyStimulus(1'b0, -1, 3, firstXfer);
    repeat (20) @(negedge clk);
    checkOutput("busyDones", doneCount - doneBase, 1);
    checkOutput("busyWords", xferCount - xferBase, NUM_WORDS);
    checkOutput("busyShifts", pmCount - pmBase, CHAIN_BITS);
    checkChain("busyChain", -1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
